// File: rtl/adc_mock_pkg.sv
// -----------------------------------------------------------------------------
// adc_mock_pkg
// Shared definitions for the multi-channel mock ADC.
//   state_t       : conversion sequencer states (IDLE, SAMPLE, CONVERT, DONE)
//   defaultStride : default per-channel data offset, 2**wordSize / channels
// -----------------------------------------------------------------------------
package adc_mock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The channels split the sample value range into equal slices, so that each
  // channel's data stream is easy to tell apart on a waveform.
  function automatic int defaultStride(input int wordSize, input int channels);
    return (1 << wordSize) / channels;
  endfunction

endpackage

// File: rtl/adc_mock_source.sv
// -----------------------------------------------------------------------------
// adc_mock_source
// Per-channel sample address counters and the mock sample generator.
// Sample value = (addr[ch] + ch*CH_STRIDE) mod 2**WORD_SIZE.
//
// Optional feature (macro ADC_MOCK_TB_FORCE_EN): i_tb_force_addr / i_tb_addr
// replace addr[ch] in the sample calculation; the counter itself is unaffected.
//
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_enable          advance the address counter of channel i_ch by one
//   i_ch              channel being addressed
//   i_tb_force_addr   (optional) use i_tb_addr instead of addr[ch]
//   i_tb_addr         (optional) forced address
//   o_data            sample value for channel i_ch
// -----------------------------------------------------------------------------
module adc_mock_source
  import adc_mock_pkg::*;
#(
  parameter int  WORD_SIZE  = 8,
  parameter int  CHANNELS   = 4,
  parameter int  ADDR_DEPTH = 8,
  parameter int  CH_STRIDE  = defaultStride(WORD_SIZE, CHANNELS),
  localparam int CW         = $clog2(CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [CW-1:0]         i_ch,
`ifdef ADC_MOCK_TB_FORCE_EN
  input  logic                  i_tb_force_addr,
  input  logic [ADDR_DEPTH-1:0] i_tb_addr,
`endif
  output logic [WORD_SIZE-1:0]  o_data
);

  logic [ADDR_DEPTH-1:0] r_addr [CHANNELS];
  logic [ADDR_DEPTH-1:0] w_addrUsed;

  // Only the addressed channel advances; the natural ADDR_DEPTH-bit overflow
  // provides the wrap from 2**ADDR_DEPTH-1 back to 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < CHANNELS; i++) r_addr[i] <= '0;
    end else if (i_enable) begin
      r_addr[i_ch] <= r_addr[i_ch] + 1'b1;
    end
  end

`ifdef ADC_MOCK_TB_FORCE_EN
  assign w_addrUsed = i_tb_force_addr ? i_tb_addr : r_addr[i_ch];
`else
  assign w_addrUsed = r_addr[i_ch];
`endif

  // Truncation to WORD_SIZE bits performs the modulo 2**WORD_SIZE.
  assign o_data = WORD_SIZE'(32'(w_addrUsed) + 32'(i_ch) * 32'(CH_STRIDE));

endmodule

// File: rtl/adc_mock_multi.sv
// -----------------------------------------------------------------------------
// adc_mock_multi
// Multi-channel mock ADC. A rising TRIGGER edge starts either a single
// conversion (MODE=0, channel CH_SEL) or a scan over all channels (MODE=1).
// Each conversion is SAMPLE (1 cycle), CONVERT (DELAY_DEPTH cycles) and DONE
// (1 cycle, DVALID pulse). Trigger edges while busy set the sticky OVERRUN.
//
// Optional feature (macro ADC_MOCK_TB_FORCE_EN): i_tb_force_addr, i_tb_addr,
// i_tb_force_data, i_tb_data let a bench override the sampled address/data.
//
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_trigger        conversion request (rising edge)
//   i_ch_sel         single-mode channel, clamped to CHANNELS-1
//   i_mode           0 = single, 1 = scan
//   o_data, o_ch_out converted sample and its channel, held between results
//   o_dvalid         one-cycle result strobe
//   o_busy           sequence in progress
//   o_overrun        sticky: trigger edge seen while busy
// -----------------------------------------------------------------------------
module adc_mock_multi
  import adc_mock_pkg::*;
#(
  parameter int  WORD_SIZE   = 8,
  parameter int  CHANNELS    = 4,
  parameter int  ADDR_DEPTH  = 8,
  parameter int  DELAY_DEPTH = 5,
  parameter int  CH_STRIDE   = defaultStride(WORD_SIZE, CHANNELS),
  localparam int CW          = $clog2(CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_trigger,
  input  logic [CW-1:0]         i_ch_sel,
  input  logic                  i_mode,
`ifdef ADC_MOCK_TB_FORCE_EN
  input  logic                  i_tb_force_addr,
  input  logic [ADDR_DEPTH-1:0] i_tb_addr,
  input  logic                  i_tb_force_data,
  input  logic [WORD_SIZE-1:0]  i_tb_data,
`endif
  output logic [WORD_SIZE-1:0]  o_data,
  output logic [CW-1:0]         o_ch_out,
  output logic                  o_dvalid,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int DW = $clog2(DELAY_DEPTH + 1);

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_trigPrev;
  logic                 r_armed;
  logic                 w_edge;
  logic [CW-1:0]        w_selCh;
  logic [CW-1:0]        r_ch;
  logic                 r_mode;
  logic [DW-1:0]        r_delayCnt;
  logic [WORD_SIZE-1:0] r_sample;
  logic [WORD_SIZE-1:0] r_data;
  logic [CW-1:0]        r_chOut;
  logic                 r_overrun;
  logic [WORD_SIZE-1:0] w_srcData;
  logic [WORD_SIZE-1:0] w_captureData;
  logic                 w_lastCh;

  // r_armed stays low after reset until TRIGGER has been seen low once, so a
  // TRIGGER held high through reset release cannot masquerade as an edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_trigPrev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_trigPrev <= i_trigger;
      r_armed    <= r_armed | ~i_trigger;
    end
  end

  assign w_edge   = i_trigger & ~r_trigPrev & r_armed;
  assign w_selCh  = ({1'b0, i_ch_sel} >= (CW+1)'(CHANNELS)) ? CW'(CHANNELS - 1) : i_ch_sel;
  assign w_lastCh = (r_ch == CW'(CHANNELS - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic. Only IDLE accepts a trigger; an edge in DONE is an
  // overrun even when DONE is about to return to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (w_edge) w_nextState = ST_SAMPLE;
      ST_SAMPLE:  w_nextState = ST_CONVERT;
      ST_CONVERT: if (r_delayCnt == '0) w_nextState = ST_DONE;
      ST_DONE:    w_nextState = (r_mode && !w_lastCh) ? ST_SAMPLE : ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    o_busy   = (r_state != ST_IDLE);
    o_dvalid = (r_state == ST_DONE);
  end

  // Sequencer datapath: channel/mode latch, sample capture, delay counter and
  // the result registers, which are loaded on entry to DONE and then held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ch       <= '0;
      r_mode     <= 1'b0;
      r_delayCnt <= '0;
      r_sample   <= '0;
      r_data     <= '0;
      r_chOut    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_ch   <= i_mode ? '0 : w_selCh;
            r_mode <= i_mode;
          end
        end
        ST_SAMPLE: begin
          r_sample   <= w_captureData;
          r_delayCnt <= DW'(DELAY_DEPTH - 1);
        end
        ST_CONVERT: begin
          if (r_delayCnt == '0) begin
            r_data  <= r_sample;
            r_chOut <= r_ch;
          end else begin
            r_delayCnt <= r_delayCnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (r_mode && !w_lastCh) r_ch <= r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: any accepted-looking edge while a sequence is running.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                         r_overrun <= 1'b0;
    else if (w_edge && r_state != ST_IDLE) r_overrun <= 1'b1;
  end

  adc_mock_source #(
    .WORD_SIZE  (WORD_SIZE),
    .CHANNELS   (CHANNELS),
    .ADDR_DEPTH (ADDR_DEPTH),
    .CH_STRIDE  (CH_STRIDE)
  ) u_source (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_enable        (r_state == ST_DONE),
    .i_ch            (r_ch),
`ifdef ADC_MOCK_TB_FORCE_EN
    .i_tb_force_addr (i_tb_force_addr),
    .i_tb_addr       (i_tb_addr),
`endif
    .o_data          (w_srcData)
  );

`ifdef ADC_MOCK_TB_FORCE_EN
  assign w_captureData = i_tb_force_data ? i_tb_data : w_srcData;
`else
  assign w_captureData = w_srcData;
`endif

  assign o_data    = r_data;
  assign o_ch_out  = r_chOut;
  assign o_overrun = r_overrun;

endmodule
